lfsr_random: RTL and testbench

- Free-running 16-bit maximal-length Galois LFSR pseudo-random source for the memory/IO stage.
- Its output is mirrored every clock into a memory-mapped RAM word that software reads as a random number.
- Software reseeds it by writing a seed value; the memory stage presents that value on mem_val.
- Purely synchronous; one state register plus one seed-tracking register.

---
 rtl/lfsr_random_if.sv | 18 +
 rtl/lfsr_random.sv | 37 +++
 tb/tb_lfsr_random.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lfsr_random_if.sv
// Seed/readback bus between the memory stage and the LFSR random source.
// Ports: mem_val (seed written by software), out (current random value).
interface lfsr_random_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] mem_val;
    logic [WIDTH-1:0] out;

    modport master (
        output mem_val,
        input  out
    );

    modport slave (
        input  mem_val,
        output out
    );
endinterface

// File: rtl/lfsr_random.sv
// Free-running 16-bit maximal-length Galois LFSR with change-triggered reseed.
// Ports: clk, rst (sync, active-low), bus.mem_val (seed in), bus.out (state).
module lfsr_random #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0]   TAPS  = 16'hB400
) (
    input  logic         clk,
    input  logic         rst,
    lfsr_random_if.slave bus
);
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] nxt;
    logic             reseed;
    logic [WIDTH-1:0] seed_val;

    assign nxt      = (state >> 1) ^ (state[0] ? TAPS : '0);
    assign reseed   = (bus.mem_val != seed_q);
    // Zero would lock the LFSR up, so it maps onto the default seed.
    assign seed_val = (bus.mem_val == '0) ? SEED : bus.mem_val;

    // seed_q is captured during reset too, so a seed held across reset
    // does not trigger a spurious reseed afterwards.
    always_ff @(posedge clk) begin
        seed_q <= bus.mem_val;
        if (!rst) begin
            state <= SEED;
        end else if (reseed) begin
            state <= seed_val;
        end else begin
            state <= nxt;
        end
    end

    assign bus.out = state;
endmodule

// File: tb/tb_lfsr_random.sv
// Self-checking bench for lfsr_random: vector table, reseed corners, period.
// Expected values come from constants and a small reference model.
module tb_lfsr_random;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [15:0] exp_q[$];
    logic [15:0] m;
    bit   seen [0:65535];

    lfsr_random_if #(.WIDTH(16)) bus ();

    lfsr_random dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        r;
        logic [15:0] mv;
        logic [15:0] ex;
    } vec_t;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] t;
        t = {1'b0, s[15:1]};
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: out=%h required=%h", name, act, req);
    endtask

    // Drive one cycle's inputs, queue the expectation, compare after the edge.
    task automatic cyc(input string name, input logic r,
                       input logic [15:0] mv, input logic [15:0] ex);
        logic [15:0] e;
        @(negedge clk);
        rst = r;
        bus.mem_val = mv;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(name, bus.out, e);
    endtask

    vec_t vt[$];
    int   bad;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b0;
        bus.mem_val = 16'h0000;

        vt = '{
            '{1'b0, 16'h0000, 16'hACE1},
            '{1'b1, 16'h0000, 16'hE270},
            '{1'b1, 16'h0000, 16'h7138},
            '{1'b1, 16'h0000, 16'h389C},
            '{1'b1, 16'h0000, 16'h1C4E},
            '{1'b1, 16'h0000, 16'h0E27},
            '{1'b1, 16'h0000, 16'hB313},
            '{1'b1, 16'h1234, 16'h1234},
            '{1'b1, 16'h1234, 16'h091A},
            '{1'b1, 16'h1234, 16'h048D},
            '{1'b1, 16'h1234, 16'hB646},
            '{1'b1, 16'h0000, 16'hACE1},
            '{1'b1, 16'h0000, 16'hE270}
        };
        foreach (vt[i]) cyc($sformatf("vec%0d", i), vt[i].r, vt[i].mv, vt[i].ex);

        // Constant seed: exactly one reseed, then plain stepping.
        cyc("const_load", 1'b1, 16'h5555, 16'h5555);
        m = 16'h5555;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            m = model_step(m);
            cyc("const_step", 1'b1, 16'h5555, m);
            if (bus.out == 16'h5555) bad++;
        end
        n_total++;
        if (bad == 0) n_pass++;
        else $display("FAIL const_revisit: hits=%0d required=0", bad);

        // Reset coincides with a seed change: reset wins, no later reseed.
        cyc("prio_rst", 1'b0, 16'hBEEF, 16'hACE1);
        cyc("prio_norsd", 1'b1, 16'hBEEF, 16'hE270);
        cyc("prio_step", 1'b1, 16'hBEEF, 16'h7138);
        // A seed change arriving in the same cycle as reset release.
        cyc("rst_rel_rsd", 1'b0, 16'hBEEF, 16'hACE1);
        cyc("rst_rel_chg", 1'b1, 16'h00FF, 16'h00FF);

        // Full period from reset.
        cyc("per_rst", 1'b0, 16'h0000, 16'hACE1);
        m = 16'hACE1;
        seen[16'hACE1] = 1'b1;
        bad = 0;
        for (int i = 1; i <= 65535; i++) begin
            m = model_step(m);
            cyc("per_step", 1'b1, 16'h0000, m);
            if (i < 65535) begin
                if (bus.out == 16'h0000 || seen[bus.out]) bad++;
                seen[bus.out] = 1'b1;
            end
        end
        chk("per_wrap", bus.out, 16'hACE1);
        n_total++;
        if (bad == 0) n_pass++;
        else $display("FAIL per_distinct: repeats_or_zero=%0d required=0", bad);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
